sync_fifo_param: RTL and testbench
==================================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 Parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W entries (ADDR_W>=2).
REQ-003 Port clk, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-005 Port write, input, 1, write request.
REQ-006 Port read, input, 1, read request.
REQ-007 Port data_in, input, DATA_W, write data.
REQ-008 Port clr_err, input, 1, clears sticky error flags.
REQ-009 Port afull_thresh, input, ADDR_W+1, almost-full threshold (entries).
REQ-010 Port aempty_thresh, input, ADDR_W+1, almost-empty threshold (entries).
REQ-011 Port data_out, output, DATA_W, registered read data.
REQ-012 Port data_valid, output, 1, one-cycle pulse qualifying data_out.
REQ-013 Port level, output, ADDR_W+1, current occupancy, 0..DEPTH.
REQ-014 Port is_full, is_empty, almost_full, almost_empty, output, 1 each, status flags.
REQ-015 Port overflow, underflow, output, 1 each, sticky error flags.

Function
REQ-016 Write/read pointers SHALL be ADDR_W+1 bits, wrapping modulo 2**(ADDR_W+1); storage index = low ADDR_W bits.
REQ-017 is_full SHALL be 1 iff pointer MSBs differ and low bits are equal; is_empty iff pointers are fully equal; both combinational from registered pointers.
REQ-018 level SHALL equal wptr - rptr (ADDR_W+1-bit modular subtraction).
REQ-019 rd_acc = read & ~is_empty; wr_acc = write & (~is_full | rd_acc).
REQ-020 Write while full SHALL be accepted only when a read is accepted the same cycle; level then stays DEPTH.
REQ-021 Read while empty SHALL be rejected even if a write is accepted the same cycle (no fall-through).
REQ-022 On wr_acc, data_in SHALL be stored at wptr index and wptr incremented at that edge.
REQ-023 On rd_acc, entry at rptr index SHALL be registered into data_out and rptr incremented at that edge; data_valid SHALL be 1 in the following cycle only.
REQ-024 Read latency: data_out valid exactly 1 cycle after the rd_acc edge; data_out SHALL hold its value when no read is accepted.
REQ-025 Simultaneous accepted read and write SHALL leave level unchanged; a read of the slot being written the same cycle cannot occur (empty rule).
REQ-026 almost_full = (level >= afull_thresh); almost_empty = (level <= aempty_thresh); unsigned compare, combinational.
REQ-027 overflow SHALL set on the edge after write & ~wr_acc; underflow SHALL set on the edge after read & ~rd_acc.
REQ-028 Flags SHALL stay set until clr_err=1 at a rising edge; if set condition and clr_err coincide, the flag SHALL be 1 (set wins).
REQ-029 Rejected requests SHALL not modify pointers, storage or data_out.

Reset
REQ-030 rst=1 at a rising edge SHALL zero wptr, rptr, data_out, data_valid, overflow, underflow; storage contents need not be cleared.
REQ-031 After reset: level=0, is_empty=1, is_full=0, almost_empty=1 if aempty_thresh>=0 (always), almost_full=(afull_thresh==0).
REQ-032 rst SHALL override all concurrent write/read/clr_err in that cycle, including mid-burst; no pending data_valid survives.

Verification
REQ-033 Defaults; write 0x01..0x10 on 16 cycles -> is_full=1, level=16; 17th write -> overflow=1, level stays 16.
REQ-034 Full FIFO, read+write(0xAA) same cycle -> data_out=0x01 next cycle with data_valid=1, level=16, overflow unchanged.
REQ-035 Empty FIFO, read+write(0x55) same cycle -> underflow=1, data_valid=0, level=1; next read returns 0x55.
REQ-036 Write/read 40 words streaming -> pointers wrap twice, output sequence equals input, is_full never asserted.
REQ-037 afull_thresh=12, aempty_thresh=3: fill to 12 -> almost_full=1 at level 12 only; drain to 3 -> almost_empty=1; clr_err with concurrent overflow condition -> overflow stays 1.
REQ-038 Assert rst mid-burst at level 7 -> next cycle level=0, is_empty=1, data_valid=0, overflow=underflow=0, data_out=0.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_param_if -- handshake/status bundle for sync_fifo_param.
//   master : the FIFO user; drives write/read requests, write data, error
//            clear and the almost-full/almost-empty thresholds.
//   slave  : the FIFO itself; drives read data, data_valid, occupancy,
//            status flags and sticky error flags.
// ---------------------------------------------------------------------------
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              write;
  logic              read;
  logic [DATA_W-1:0] data_in;
  logic              clr_err;
  logic [ADDR_W:0]   afull_thresh;
  logic [ADDR_W:0]   aempty_thresh;

  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [ADDR_W:0]   level;
  logic              is_full;
  logic              is_empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  modport master (
    output write, read, data_in, clr_err, afull_thresh, aempty_thresh,
    input  data_out, data_valid, level, is_full, is_empty,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  write, read, data_in, clr_err, afull_thresh, aempty_thresh,
    output data_out, data_valid, level, is_full, is_empty,
           almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param -- single-clock FIFO, DEPTH = 2**ADDR_W words of DATA_W bits.
//   clk  : sole clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : sync_fifo_param_if.slave
//          write/read/data_in requests, registered data_out with a one-cycle
//          data_valid pulse, level (0..DEPTH), full/empty/almost flags and
//          sticky overflow/underflow errors cleared by clr_err.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A write into a full FIFO is accepted when a read is accepted in the same
// cycle; a read of an empty FIFO is always rejected (no fall-through).
// ---------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  sync_fifo_param_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;
  logic              overflow_q;
  logic              underflow_q;

  logic              full;
  logic              empty;
  logic              rd_acc;
  logic              wr_acc;
  logic [ADDR_W:0]   level;

  // Full: same slot, opposite lap. Empty: identical pointers.
  assign full   = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                  (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign empty  = (wptr == rptr);
  assign level  = wptr - rptr;

  assign rd_acc = bus.read & ~empty;
  // A concurrent accepted read frees the slot this write lands in.
  assign wr_acc = bus.write & (~full | rd_acc);

  // NOTE: storage has no reset; stale contents are unreachable once the
  // pointers are zeroed, and leaving it out keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wptr[ADDR_W-1:0]] <= bus.data_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) begin
        rptr       <= rptr + 1'b1;
        data_out_q <= mem[rptr[ADDR_W-1:0]];
      end
      data_valid_q <= rd_acc;
      // Set has priority over clear.
      overflow_q   <= (bus.write & ~wr_acc) | (overflow_q  & ~bus.clr_err);
      underflow_q  <= (bus.read  & ~rd_acc) | (underflow_q & ~bus.clr_err);
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.data_valid   = data_valid_q;
  assign bus.level        = level;
  assign bus.is_full      = full;
  assign bus.is_empty     = empty;
  assign bus.almost_full  = (level >= bus.afull_thresh);
  assign bus.almost_empty = (level <= bus.aempty_thresh);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param -- self-checking bench for sync_fifo_param (defaults).
// Reference model: a queue of words plus the expected registered outputs,
// updated once per clock from the FIFO's acceptance rules.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  sync_fifo_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_dout = '0;
  logic              m_dv   = 1'b0;
  logic              m_ovf  = 1'b0;
  logic              m_udf  = 1'b0;

  // Drive one clock cycle of stimulus and advance the model. Inputs change
  // 1 ns after a rising edge; outputs are therefore sampled there too.
  task automatic cycle(input logic w, input logic r, input logic [DATA_W-1:0] d,
                       input logic clr, input logic rs);
    bit ra, wa;
    bus.write   = w;
    bus.read    = r;
    bus.data_in = d;
    bus.clr_err = clr;
    rst         = rs;
    ra = r && (m_q.size() > 0);
    wa = w && ((m_q.size() < DEPTH) || ra);
    @(posedge clk);
    #1;
    if (rs) begin
      m_q.delete();
      m_dout = '0;
      m_dv   = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      m_dv = ra;
      if (ra) m_dout = m_q.pop_front();
      if (wa) m_q.push_back(d);
      m_ovf = (w && !wa) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_udf = (r && !ra) ? 1'b1 : (clr ? 1'b0 : m_udf);
    end
    bus.write   = 1'b0;
    bus.read    = 1'b0;
    bus.clr_err = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic test_reset();
    bus.afull_thresh  = 5'd16;
    bus.aempty_thresh = 5'd0;
    cycle(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
    n_total++; if (bus.level !== 5'd0) $display("FAIL reset_level got %0d want 0", bus.level); else n_pass++;
    n_total++; if (bus.is_empty !== 1'b1) $display("FAIL reset_empty got %b want 1", bus.is_empty); else n_pass++;
    n_total++; if (bus.is_full !== 1'b0) $display("FAIL reset_full got %b want 0", bus.is_full); else n_pass++;
    n_total++; if (bus.almost_empty !== 1'b1) $display("FAIL reset_aempty got %b want 1", bus.almost_empty); else n_pass++;
    n_total++; if (bus.almost_full !== 1'b0) $display("FAIL reset_afull got %b want 0", bus.almost_full); else n_pass++;
    n_total++; if (bus.data_valid !== 1'b0 || bus.data_out !== 8'h00)
      $display("FAIL reset_dout got dv=%b do=%h want dv=0 do=00", bus.data_valid, bus.data_out); else n_pass++;
    n_total++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0)
      $display("FAIL reset_err got ovf=%b udf=%b want 0 0", bus.overflow, bus.underflow); else n_pass++;
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
    n_total++; if (bus.is_full !== 1'b1) $display("FAIL fill_full got %b want 1", bus.is_full); else n_pass++;
    n_total++; if (bus.level !== 5'd16) $display("FAIL fill_level got %0d want 16", bus.level); else n_pass++;
    n_total++; if (bus.overflow !== 1'b0) $display("FAIL fill_no_ovf got %b want 0", bus.overflow); else n_pass++;
    cycle(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    n_total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", bus.overflow); else n_pass++;
    n_total++; if (bus.level !== 5'd16) $display("FAIL ovf_level got %0d want 16", bus.level); else n_pass++;
  endtask

  task automatic test_full_rw();
    cycle(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
    n_total++; if (bus.data_out !== 8'h01 || bus.data_valid !== 1'b1)
      $display("FAIL full_rw_dout got dv=%b do=%h want dv=1 do=01", bus.data_valid, bus.data_out); else n_pass++;
    n_total++; if (bus.level !== 5'd16) $display("FAIL full_rw_level got %0d want 16", bus.level); else n_pass++;
    n_total++; if (bus.overflow !== 1'b1) $display("FAIL full_rw_ovf got %b want 1", bus.overflow); else n_pass++;
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    n_total++; if (bus.data_valid !== 1'b0 || bus.data_out !== 8'h01)
      $display("FAIL dout_hold got dv=%b do=%h want dv=0 do=01", bus.data_valid, bus.data_out); else n_pass++;
    // Drain and confirm order, including the word written while full.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      n_total++; if (bus.data_valid !== 1'b1 || bus.data_out !== m_dout)
        $display("FAIL drain_%0d got dv=%b do=%h want dv=1 do=%h", i, bus.data_valid, bus.data_out, m_dout); else n_pass++;
    end
    n_total++; if (m_dout !== 8'hAA || bus.is_empty !== 1'b1)
      $display("FAIL drain_last got empty=%b model=%h want empty=1 model=aa", bus.is_empty, m_dout); else n_pass++;
  endtask

  task automatic test_empty_rw();
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    n_total++; if (bus.underflow !== 1'b1) $display("FAIL empty_rw_udf got %b want 1", bus.underflow); else n_pass++;
    n_total++; if (bus.data_valid !== 1'b0) $display("FAIL empty_rw_dv got %b want 0", bus.data_valid); else n_pass++;
    n_total++; if (bus.level !== 5'd1) $display("FAIL empty_rw_level got %0d want 1", bus.level); else n_pass++;
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    n_total++; if (bus.data_out !== 8'h55 || bus.data_valid !== 1'b1)
      $display("FAIL empty_rw_read got dv=%b do=%h want dv=1 do=55", bus.data_valid, bus.data_out); else n_pass++;
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_total++; if (bus.underflow !== 1'b0) $display("FAIL udf_clear got %b want 0", bus.underflow); else n_pass++;
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] sent[$];
    int got = 0;
    bit saw_full = 0;
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 41; i++) begin
      logic [DATA_W-1:0] d = 8'($urandom);
      if (i < 40) sent.push_back(d);
      cycle(i < 40, i > 0, d, 1'b0, 1'b0);
      if (bus.is_full === 1'b1) saw_full = 1;
      if (bus.data_valid === 1'b1) begin
        n_total++; if (bus.data_out !== sent[got])
          $display("FAIL stream_%0d got %h want %h", got, bus.data_out, sent[got]); else n_pass++;
        got++;
      end
    end
    n_total++; if (got !== 40) $display("FAIL stream_count got %0d want 40", got); else n_pass++;
    n_total++; if (saw_full !== 1'b0) $display("FAIL stream_full got %b want 0", saw_full); else n_pass++;
    n_total++; if (bus.is_empty !== 1'b1) $display("FAIL stream_empty got %b want 1", bus.is_empty); else n_pass++;
  endtask

  task automatic test_thresholds();
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    bus.afull_thresh  = 5'd12;
    bus.aempty_thresh = 5'd3;
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
      n_total++; if (bus.almost_full !== (i >= 12))
        $display("FAIL afull_lvl%0d got %b want %b", i, bus.almost_full, i >= 12); else n_pass++;
    end
    for (int i = 11; i >= 3; i--) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      n_total++; if (bus.almost_empty !== (i <= 3))
        $display("FAIL aempty_lvl%0d got %b want %b", i, bus.almost_empty, i <= 3); else n_pass++;
    end
    while (m_q.size() < DEPTH) cycle(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h44, 1'b1, 1'b0);
    n_total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_set_wins got %b want 1", bus.overflow); else n_pass++;
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    n_total++; if (bus.overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", bus.overflow); else n_pass++;
  endtask

  task automatic test_random();
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      int wp = (i < 200) ? 75 : (i < 400) ? 25 : 50;
      if (i % 50 == 0) begin
        bus.afull_thresh  = 5'($urandom_range(0, DEPTH));
        bus.aempty_thresh = 5'($urandom_range(0, DEPTH));
      end
      cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
            8'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
      n_total++;
      if (bus.level !== 5'(m_q.size()) || bus.is_full !== (m_q.size() == DEPTH) ||
          bus.is_empty !== (m_q.size() == 0) ||
          bus.almost_full !== (m_q.size() >= int'(bus.afull_thresh)) ||
          bus.almost_empty !== (m_q.size() <= int'(bus.aempty_thresh)))
        $display("FAIL rand_status_%0d got lvl=%0d f=%b e=%b af=%b ae=%b want lvl=%0d", i,
                 bus.level, bus.is_full, bus.is_empty, bus.almost_full, bus.almost_empty, m_q.size());
      else n_pass++;
      n_total++;
      if (bus.data_valid !== m_dv || bus.data_out !== m_dout ||
          bus.overflow !== m_ovf || bus.underflow !== m_udf)
        $display("FAIL rand_data_%0d got dv=%b do=%h ovf=%b udf=%b want dv=%b do=%h ovf=%b udf=%b", i,
                 bus.data_valid, bus.data_out, bus.overflow, bus.underflow, m_dv, m_dout, m_ovf, m_udf);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_burst();
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'h80 + i), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    n_total++; if (bus.level !== 5'd7 || bus.data_valid !== 1'b1 || bus.underflow !== 1'b1)
      $display("FAIL burst_pre got lvl=%0d dv=%b udf=%b want 7 1 1", bus.level, bus.data_valid, bus.underflow); else n_pass++;
    cycle(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1);
    n_total++; if (bus.level !== 5'd0 || bus.is_empty !== 1'b1)
      $display("FAIL burst_rst_level got lvl=%0d empty=%b want 0 1", bus.level, bus.is_empty); else n_pass++;
    n_total++; if (bus.data_valid !== 1'b0 || bus.data_out !== 8'h00)
      $display("FAIL burst_rst_dout got dv=%b do=%h want 0 00", bus.data_valid, bus.data_out); else n_pass++;
    n_total++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0)
      $display("FAIL burst_rst_err got ovf=%b udf=%b want 0 0", bus.overflow, bus.underflow); else n_pass++;
  endtask

  initial begin
    bus.write         = 1'b0;
    bus.read          = 1'b0;
    bus.data_in       = '0;
    bus.clr_err       = 1'b0;
    bus.afull_thresh  = 5'd16;
    bus.aempty_thresh = 5'd0;
    test_reset();
    test_fill_overflow();
    test_full_rw();
    test_empty_rw();
    test_stream();
    test_thresholds();
    test_random();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
